flopr_pipe: RTL and testbench



---
 rtl/flopr_pipe_pkg.sv | 13 +
 rtl/flopr_pipe_flopenrc.sv | 25 ++
 rtl/flopr_pipe.sv | 95 +++++++++
 tb/tb_flopr_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/flopr_pipe_pkg.sv
// Shared defaults and sizing helpers for the flopr_pipe pipeline register.
// The per-stage {valid, data} bundle is declared in flopr_pipe, where WIDTH is known.
package flopr_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;

  // Width of an occupancy counter that must hold 0..depth without wrapping.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flopr_pipe_flopenrc.sv
// One storage stage: async reset and sync clear to RESET_VAL, load on en, else hold.
// Single-cycle latency; clear takes priority over en.
module flopenrc #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flopr_pipe.sv
// DEPTH-stage pipeline register with per-stage valid, stall, flush and occupancy count; latency DEPTH when en=1.
// ready_in=en normally; with FLOPR_PIPE_BUBBLE_COLLAPSE_EN defined, empty stages keep filling during a stall.
module flopr_pipe
  import flopr_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           d,
  output logic                       ready_in,
  output logic [WIDTH-1:0]           y,
  output logic                       valid_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_in [DEPTH];
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] adv;
  logic             run;
  logic [CW-1:0]    cnt;

  // Advance chain, walked from the output stage back toward stage 0.
  // In collapse mode a stage also advances when it is itself empty, so a stage only
  // overwrites a valid item when its successor is taking that item the same edge.
  always_comb begin
    adv            = '0;
    run            = en;
    adv[DEPTH-1]   = en;
    for (int k = DEPTH - 2; k >= 0; k--) begin
`ifdef FLOPR_PIPE_BUBBLE_COLLAPSE_EN
      run = run | ~valid_q[k];
`endif
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = '{valid: valid_in, data: d};
    end else begin : g_body
      assign stage_in[k] = '{valid: valid_q[k-1], data: data_q[k-1]};
    end

    flopenrc #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_data (
      .clk  (clk),
      .reset(reset),
      .en   (adv[k]),
      .clr  (clr),
      .d    (stage_in[k].data),
      .q    (data_q[k])
    );

    flopenrc #(
      .WIDTH    (1),
      .RESET_VAL(1'b0)
    ) u_valid (
      .clk  (clk),
      .reset(reset),
      .en   (adv[k]),
      .clr  (clr),
      .d    (stage_in[k].valid),
      .q    (valid_q[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(valid_q[k]);
    end
  end

  assign ready_in  = adv[0];
  assign y         = data_q[DEPTH-1];
  assign valid_out = valid_q[DEPTH-1];
  assign count     = cnt;

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed self-checking bench for flopr_pipe at WIDTH=8, DEPTH=3, RESET_VAL=0.
module tb_flopr_pipe;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic       valid_in;
  logic [7:0] d;
  logic       ready_in;
  logic [7:0] y;
  logic       valid_out;
  logic [1:0] count;

  int pass_cnt;
  int total_cnt;

`ifdef FLOPR_PIPE_BUBBLE_COLLAPSE_EN
  localparam bit COLLAPSE = 1'b1;
`else
  localparam bit COLLAPSE = 1'b0;
`endif

  flopr_pipe #(
    .WIDTH    (8),
    .DEPTH    (3),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .valid_in (valid_in),
    .d        (d),
    .ready_in (ready_in),
    .y        (y),
    .valid_out(valid_out),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [7:0] dat);
    en = 1'b1; clr = 1'b0; valid_in = v; d = dat;
    tick();
  endtask

  task automatic flush();
    clr = 1'b1; en = 1'b1; valid_in = 1'b0; d = 8'h00;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; clr = 1'b0; valid_in = 1'b0; d = 8'h00;
    #2;
    total_cnt++; if (y !== 8'h00) $display("FAIL reset_y: got %h expected 00", y); else pass_cnt++;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_vo: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
    tick();
    reset = 1'b0;
    push(1'b1, 8'h11);
    push(1'b1, 8'h22);
    push(1'b1, 8'h33);
    total_cnt++; if (count !== 2'd3) $display("FAIL prereset_count: got %0d expected 3", count); else pass_cnt++;
    total_cnt++; if (y !== 8'h11) $display("FAIL prereset_y: got %h expected 11", y); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (y !== 8'h00) $display("FAIL midreset_y: got %h expected 00", y); else pass_cnt++;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL midreset_vo: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL midreset_count: got %0d expected 0", count); else pass_cnt++;
    reset = 1'b0;
    en = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] din   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    logic       vin   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] exp_y [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    logic       exp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_c [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
    for (int i = 0; i < 6; i++) begin
      push(vin[i], din[i]);
      total_cnt++; if (y !== exp_y[i]) $display("FAIL stream_y[%0d]: got %h expected %h", i, y, exp_y[i]); else pass_cnt++;
      total_cnt++; if (valid_out !== exp_v[i]) $display("FAIL stream_vo[%0d]: got %b expected %b", i, valid_out, exp_v[i]); else pass_cnt++;
      total_cnt++; if (count !== exp_c[i]) $display("FAIL stream_count[%0d]: got %0d expected %0d", i, count, exp_c[i]); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    flush();
    push(1'b1, 8'hA1);
    push(1'b1, 8'hA2);
    push(1'b1, 8'hA3);
    en = 1'b0; valid_in = 1'b1; d = 8'hB0;
    #1;
    total_cnt++; if (ready_in !== 1'b0) $display("FAIL stall_ready: got %b expected 0", ready_in); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (y !== 8'hA1) $display("FAIL stall_y[%0d]: got %h expected a1", i, y); else pass_cnt++;
      total_cnt++; if (count !== 2'd3) $display("FAIL stall_count[%0d]: got %0d expected 3", i, count); else pass_cnt++;
    end
    push(1'b0, 8'h00);
    total_cnt++; if (y !== 8'hA2) $display("FAIL unstall_y0: got %h expected a2", y); else pass_cnt++;
    push(1'b0, 8'h00);
    total_cnt++; if (y !== 8'hA3) $display("FAIL unstall_y1: got %h expected a3", y); else pass_cnt++;
    push(1'b0, 8'h00);
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL stall_nocapture_vo: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL stall_nocapture_count: got %0d expected 0", count); else pass_cnt++;
  endtask

  task automatic test_flush();
    push(1'b1, 8'hC1);
    push(1'b1, 8'hC2);
    push(1'b1, 8'hC3);
    clr = 1'b1; en = 1'b1; valid_in = 1'b1; d = 8'hFF;
    tick();
    clr = 1'b0;
    total_cnt++; if (valid_out !== 1'b0) $display("FAIL flush_vo: got %b expected 0", valid_out); else pass_cnt++;
    total_cnt++; if (y !== 8'h00) $display("FAIL flush_y: got %h expected 00", y); else pass_cnt++;
    total_cnt++; if (count !== 2'd0) $display("FAIL flush_count: got %0d expected 0", count); else pass_cnt++;
    push(1'b1, 8'h5A);
    total_cnt++; if (count !== 2'd1) $display("FAIL postflush_count: got %0d expected 1", count); else pass_cnt++;
    push(1'b0, 8'h00);
    push(1'b0, 8'h00);
    total_cnt++; if (y !== 8'h5A || valid_out !== 1'b1) $display("FAIL postflush_y: got %h/%b expected 5a/1", y, valid_out); else pass_cnt++;
  endtask

  task automatic test_bubble();
    logic       exp_rdy;
    logic [1:0] exp_cnt;
    flush();
    push(1'b1, 8'h03);
    push(1'b0, 8'h00);
    push(1'b1, 8'h01);
    total_cnt++; if (count !== 2'd2) $display("FAIL bubble_setup_count: got %0d expected 2", count); else pass_cnt++;
    en = 1'b0; valid_in = 1'b1; d = 8'h04;
    #1;
    exp_rdy = COLLAPSE;
    exp_cnt = COLLAPSE ? 2'd3 : 2'd2;
    total_cnt++; if (ready_in !== exp_rdy) $display("FAIL bubble_ready: got %b expected %b", ready_in, exp_rdy); else pass_cnt++;
    tick();
    total_cnt++; if (y !== 8'h03 || valid_out !== 1'b1) $display("FAIL bubble_y: got %h/%b expected 03/1", y, valid_out); else pass_cnt++;
    total_cnt++; if (count !== exp_cnt) $display("FAIL bubble_count: got %0d expected %0d", count, exp_cnt); else pass_cnt++;
    push(1'b0, 8'h00);
    if (COLLAPSE) begin
      total_cnt++; if (y !== 8'h01 || valid_out !== 1'b1) $display("FAIL bubble_drain0: got %h/%b expected 01/1", y, valid_out); else pass_cnt++;
    end else begin
      total_cnt++; if (valid_out !== 1'b0) $display("FAIL bubble_drain0: got vo %b expected 0", valid_out); else pass_cnt++;
    end
    push(1'b0, 8'h00);
    if (COLLAPSE) begin
      total_cnt++; if (y !== 8'h04 || valid_out !== 1'b1) $display("FAIL bubble_drain1: got %h/%b expected 04/1", y, valid_out); else pass_cnt++;
    end else begin
      total_cnt++; if (y !== 8'h01 || valid_out !== 1'b1) $display("FAIL bubble_drain1: got %h/%b expected 01/1", y, valid_out); else pass_cnt++;
    end
  endtask

  task automatic test_passthrough();
    logic [7:0] din [4] = '{8'h77, 8'h88, 8'h99, 8'hAA};
    flush();
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; valid_in = 1'b0; d = din[i];
      #1;
      total_cnt++; if (ready_in !== 1'b1) $display("FAIL pass_ready[%0d]: got %b expected 1", i, ready_in); else pass_cnt++;
      tick();
      total_cnt++; if (count !== 2'd0 || valid_out !== 1'b0) $display("FAIL pass_valid[%0d]: got count %0d vo %b expected 0/0", i, count, valid_out); else pass_cnt++;
    end
    total_cnt++; if (y !== 8'h88) $display("FAIL pass_shift_y: got %h expected 88", y); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_passthrough();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
